// File: rtl/panel_input_conditioner_pkg.sv
// rtl/panel_input_conditioner_pkg.sv - shared types and constants for the panel input conditioner
package panel_input_conditioner_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE         = 2'd0,
        KEY_PRESS_WAIT   = 2'd1,
        KEY_HELD         = 2'd2,
        KEY_RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int SW_W = 8;

    // Levels the synchronizers reset to: key released, switches off
    localparam logic            KEY_IDLE_LEVEL = 1'b1;
    localparam logic [SW_W-1:0] SW_IDLE_LEVEL  = '0;

endpackage

// File: rtl/panel_input_conditioner_sync2.sv
// rtl/panel_input_conditioner_sync2.sv - two-flop synchronizer with asynchronous preset value
module panel_input_conditioner_sync2 #(
    parameter int           W      = 1,
    parameter logic [W-1:0] PRESET = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= PRESET;
            q    <= PRESET;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/panel_input_conditioner.sv
// rtl/panel_input_conditioner.sv - synchronize, debounce and snapshot panel key and switch inputs
module panel_input_conditioner
    import panel_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       next_raw_n,
    input  logic       level_raw,
    input  logic [2:0] ms_raw,
    input  logic [3:0] din_raw,
    output logic       next_pulse,
    output logic       next_held,
    output logic       level_q,
    output logic [2:0] ms_q,
    output logic [3:0] din_q,
    output logic [3:0] din_snap,
    output logic [2:0] ms_snap,
    output logic       sw_changed
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            key_sync;
    logic            pressed;
    logic [SW_W-1:0] sw_sync;
    logic [SW_W-1:0] sw_cand;
    logic [SW_W-1:0] sw_out;
    logic [CNT_W-1:0] kcnt;
    logic [CNT_W-1:0] scnt;
    key_state_t      key_state;

    panel_input_conditioner_sync2 #(.W(1), .PRESET(KEY_IDLE_LEVEL)) u_key_sync (
        .clk   (clk),
        .rst_n (clear),
        .d     (next_raw_n),
        .q     (key_sync)
    );

    panel_input_conditioner_sync2 #(.W(SW_W), .PRESET(SW_IDLE_LEVEL)) u_sw_sync (
        .clk   (clk),
        .rst_n (clear),
        .d     ({level_raw, ms_raw, din_raw}),
        .q     (sw_sync)
    );

    assign pressed = ~key_sync;
    assign sw_out  = {level_q, ms_q, din_q};

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            key_state  <= KEY_IDLE;
            kcnt       <= '0;
            next_pulse <= 1'b0;
            next_held  <= 1'b0;
            din_snap   <= '0;
            ms_snap    <= '0;
        end else begin
            next_pulse <= 1'b0;
            case (key_state)
                KEY_IDLE: begin
                    if (pressed) begin
                        key_state <= KEY_PRESS_WAIT;
                        kcnt      <= '0;
                    end
                end
                KEY_PRESS_WAIT: begin
                    if (!pressed) begin
                        key_state <= KEY_IDLE;
                        kcnt      <= '0;
                    end else if (kcnt == CNT_TERM) begin
                        // Snapshot takes the outputs as they stand before any same-edge switch update
                        key_state  <= KEY_HELD;
                        next_pulse <= 1'b1;
                        next_held  <= 1'b1;
                        din_snap   <= din_q;
                        ms_snap    <= ms_q;
                    end else begin
                        kcnt <= kcnt + CNT_W'(1);
                    end
                end
                KEY_HELD: begin
                    if (!pressed) begin
                        key_state <= KEY_RELEASE_WAIT;
                        kcnt      <= '0;
                    end
                end
                KEY_RELEASE_WAIT: begin
                    if (pressed) begin
                        key_state <= KEY_HELD;
                    end else if (kcnt == CNT_TERM) begin
                        key_state <= KEY_IDLE;
                        next_held <= 1'b0;
                    end else begin
                        kcnt <= kcnt + CNT_W'(1);
                    end
                end
                default: key_state <= KEY_IDLE;
            endcase
        end
    end

    // scnt saturates at CNT_TERM, so a settled candidate equal to the outputs stays quiet
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sw_cand    <= SW_IDLE_LEVEL;
            scnt       <= '0;
            level_q    <= 1'b0;
            ms_q       <= '0;
            din_q      <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= 1'b0;
            if (sw_sync != sw_cand) begin
                sw_cand <= sw_sync;
                scnt    <= '0;
            end else if (scnt != CNT_TERM) begin
                scnt <= scnt + CNT_W'(1);
            end else if (sw_cand != sw_out) begin
                {level_q, ms_q, din_q} <= sw_cand;
                sw_changed             <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_panel_input_conditioner.sv
// tb/tb_panel_input_conditioner.sv - self-checking bench for panel_input_conditioner
module tb_panel_input_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       clear;
    logic       next_raw_n;
    logic       level_raw;
    logic [2:0] ms_raw;
    logic [3:0] din_raw;
    logic       next_pulse;
    logic       next_held;
    logic       level_q;
    logic [2:0] ms_q;
    logic [3:0] din_q;
    logic [3:0] din_snap;
    logic [2:0] ms_snap;
    logic       sw_changed;

    int checks   = 0;
    int failures = 0;

    logic       key_hist[$];
    logic [7:0] sw_hist[$];
    logic       m_pulse;
    logic       m_held;
    logic       m_changed;
    logic [7:0] m_sw;
    logic [3:0] m_din_snap;
    logic [2:0] m_ms_snap;
    logic [7:0] last_sw;
    logic       prev_pulse;
    int         krun;
    int         srun;

    panel_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk        (clk),
        .clear      (clear),
        .next_raw_n (next_raw_n),
        .level_raw  (level_raw),
        .ms_raw     (ms_raw),
        .din_raw    (din_raw),
        .next_pulse (next_pulse),
        .next_held  (next_held),
        .level_q    (level_q),
        .ms_q       (ms_q),
        .din_q      (din_q),
        .din_snap   (din_snap),
        .ms_snap    (ms_snap),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        key_hist   = '{1'b1, 1'b1};
        sw_hist    = '{8'h00, 8'h00};
        m_pulse    = 1'b0;
        m_held     = 1'b0;
        m_changed  = 1'b0;
        m_sw       = 8'h00;
        m_din_snap = 4'h0;
        m_ms_snap  = 3'h0;
        last_sw    = 8'h00;
        krun       = 0;
        srun       = 1;
    endtask

    // Inputs reach the logic two edges after being sampled; a debounced value
    // changes once a new level has been seen on D+1 consecutive edges.
    task automatic model_edge();
        logic       key_seen;
        logic [7:0] sw_seen;
        logic       prs;
        key_seen = key_hist.pop_front();
        key_hist.push_back(next_raw_n);
        sw_seen = sw_hist.pop_front();
        sw_hist.push_back({level_raw, ms_raw, din_raw});
        prs       = ~key_seen;
        m_pulse   = 1'b0;
        m_changed = 1'b0;
        krun = (prs != m_held) ? krun + 1 : 0;
        if (krun == D + 1) begin
            m_held = prs;
            krun   = 0;
            if (prs) begin
                m_pulse    = 1'b1;
                m_din_snap = m_sw[3:0];
                m_ms_snap  = m_sw[6:4];
            end
        end
        srun    = (sw_seen == last_sw) ? ((srun < 1000) ? srun + 1 : srun) : 1;
        last_sw = sw_seen;
        if (srun >= D + 1 && sw_seen != m_sw) begin
            m_sw      = sw_seen;
            m_changed = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!clear) model_reset();
        else model_edge();
        #1;
        chk("next_pulse", 8'(next_pulse), 8'(m_pulse));
        chk("next_held", 8'(next_held), 8'(m_held));
        chk("sw_out", {level_q, ms_q, din_q}, m_sw);
        chk("sw_changed", 8'(sw_changed), 8'(m_changed));
        chk("din_snap", 8'(din_snap), 8'(m_din_snap));
        chk("ms_snap", 8'(ms_snap), 8'(m_ms_snap));
        chk("pulse_consecutive", 8'(prev_pulse & next_pulse), 8'h00);
        prev_pulse = next_pulse;
    endtask

    initial begin
        clear      = 1'b0;
        next_raw_n = 1'b1;
        level_raw  = 1'b0;
        ms_raw     = 3'd0;
        din_raw    = 4'h0;
        prev_pulse = 1'b0;
        model_reset();
        step();
        step();
        chk("reset_outputs", {next_pulse, next_held, level_q, sw_changed, 4'h0}, 8'h00);
        chk("reset_vectors", {1'b0, ms_q, din_q}, 8'h00);
        clear = 1'b1;
        repeat (3) step();

        // Clean press and release
        next_raw_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("press_pulse_time", 8'(next_pulse), 8'(i == 6));
            chk("press_held_time", 8'(next_held), 8'(i >= 6));
        end
        next_raw_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("release_held_time", 8'(next_held), 8'(i < 6));
        end

        // Press bounce never qualifies
        for (int i = 0; i < 14; i++) begin
            next_raw_n = (i == 2 || i >= 5);
            step();
            chk("bounce_pulse", 8'(next_pulse), 8'h00);
            chk("bounce_held", 8'(next_held), 8'h00);
        end

        // Release bounce: no second pulse, held stays up
        next_raw_n = 1'b0;
        repeat (10) step();
        for (int i = 0; i < 12; i++) begin
            next_raw_n = (i < 2);
            step();
            chk("rel_bounce_pulse", 8'(next_pulse), 8'h00);
            chk("rel_bounce_held", 8'(next_held), 8'h01);
        end
        next_raw_n = 1'b1;
        repeat (10) step();

        // Switch update followed by a snapshot press
        din_raw = 4'hA;
        ms_raw  = 3'd5;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("sw_changed_time", 8'(sw_changed), 8'(i == 6));
        end
        chk("din_q_a", 8'(din_q), 8'h0A);
        chk("ms_q_5", 8'(ms_q), 8'h05);
        next_raw_n = 1'b0;
        repeat (8) step();
        chk("din_snap_a", 8'(din_snap), 8'h0A);
        chk("ms_snap_5", 8'(ms_snap), 8'h05);
        next_raw_n = 1'b1;
        repeat (10) step();

        // Switch update and press land on the same edge
        din_raw    = 4'h3;
        next_raw_n = 1'b0;
        repeat (7) step();
        chk("coinc_pulse", 8'(next_pulse), 8'h01);
        chk("coinc_changed", 8'(sw_changed), 8'h01);
        chk("coinc_din_snap", 8'(din_snap), 8'h0A);
        chk("coinc_din_q", 8'(din_q), 8'h03);
        next_raw_n = 1'b1;
        repeat (10) step();

        // Asynchronous reset in PRESS_WAIT, key kept held across it
        next_raw_n = 1'b0;
        repeat (4) step();
        #2;
        clear = 1'b0;
        model_reset();
        #1;
        chk("async_clear_held", {next_pulse, next_held, sw_changed, level_q, 4'h0}, 8'h00);
        chk("async_clear_din", {din_snap, din_q}, 8'h00);
        chk("async_clear_ms", {2'b00, ms_snap, ms_q}, 8'h00);
        repeat (2) step();
        clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_reset_pulse_time", 8'(next_pulse), 8'(i == 6));
        end
        next_raw_n = 1'b1;
        repeat (10) step();

        // Randomized traffic against the model, with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5) == 0) next_raw_n = ~next_raw_n;
            if ($urandom_range(7) == 0) {level_raw, ms_raw, din_raw} = 8'($urandom);
            if ($urandom_range(299) == 0) begin
                clear = 1'b0;
                step();
                clear = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/panel_input_conditioner.md
Name: panel_input_conditioner

Overview:
- Board-side front end for the calculator top level: takes raw push-button and slide-switch inputs and produces clean, clock-synchronous controls for the FSM and datapath.
- Synchronizes every input, then debounces them.
- Converts the active-low "next" key into a single-cycle step pulse.
- Snapshots the operand nibble and mode at each step, so the FSM and datapath see consistent values.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles an input must stay stable before it is accepted (5 ms at 50 MHz); benches use 4.
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- clear  in  1  asynchronous, active-low reset.
- next_raw_n  in  1  raw "next" key, low = pressed.
- level_raw  in  1  raw level switch.
- ms_raw  in  3  raw mode-select switches.
- din_raw  in  4  raw operand switches.
- next_pulse  out  1  one-cycle strobe per accepted press.
- next_held  out  1  debounced key state, 1 = pressed.
- level_q  out  1  debounced level.
- ms_q  out  3  debounced mode select.
- din_q  out  4  debounced operand.
- din_snap  out  4  din_q captured at the last next_pulse.
- ms_snap  out  3  ms_q captured at the last next_pulse.
- sw_changed  out  1  one-cycle strobe when any debounced switch output updates.

Behaviour:
- Reset (clear low, asynchronous):
  - All outputs 0.
  - Synchronizer flops preset to the idle level (key = 1, switches = 0).
  - Counters 0; key FSM in IDLE.
  - Reset mid-debounce or mid-hold aborts with no pulse.
  - After release of clear, a key already held must go through a full debounce from IDLE before next_pulse fires.
- Synchronization: two-flop synchronizer on every raw bit. Only synchronized values are used downstream.
- Key FSM (operates on synchronized pressed = ~sync(next_raw_n)):
  - IDLE: pressed -> PRESS_WAIT, kcnt = 0.
  - PRESS_WAIT:
    - If not pressed -> IDLE, kcnt = 0.
    - Else if kcnt == DEBOUNCE_CYCLES-1 -> HELD; next_pulse = 1 for exactly that one following cycle; next_held = 1.
    - Else kcnt++.
  - HELD: not pressed -> RELEASE_WAIT, kcnt = 0. No repeat pulses while held.
  - RELEASE_WAIT:
    - If pressed -> HELD (bounce ignored).
    - Else if kcnt == DEBOUNCE_CYCLES-1 -> IDLE; next_held = 0.
    - Else kcnt++.
- Key latency:
  - Raw press first sampled at edge 0 and held clean -> next_pulse high in the cycle after edge DEBOUNCE_CYCLES+2.
  - next_held rises with next_pulse and falls DEBOUNCE_CYCLES+2 edges after a clean release.
- Switch debouncer: one shared 8-bit vector {level, ms, din}.
  - scnt clears on any change of the synchronized vector versus a candidate register; the candidate is reloaded with the new vector.
  - When the vector has stayed equal to the candidate for DEBOUNCE_CYCLES cycles and the candidate differs from {level_q, ms_q, din_q}: outputs update, and sw_changed pulses for one cycle.
  - Same latency as the key path.
  - A candidate equal to the current outputs causes no update and no strobe.
- Snapshot: din_snap/ms_snap load din_q/ms_q on the same edge that asserts next_pulse.
  - If a switch update and next_pulse coincide, the snapshot takes the pre-update values.
- Counters saturate and never wrap. kcnt/scnt are held, not incremented, once the terminal value is reached.
- Invariants:
  - next_pulse never high on two consecutive cycles.
  - At most one next_pulse per HELD entry.

Decomposition:
- Shared package holds:
  - key FSM state encoding (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT, 2 bits);
  - SW_W = 8;
  - the idle-level constant for synchronizer presets.
- Natural sub-module: sync2 (parameterized-width two-flop synchronizer with asynchronous active-low preset value), instantiated once for the key and once for the switch vector.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: next_raw_n low from edge 0, held 20 cycles -> next_pulse high only in the cycle after edge 6; next_held = 1 from that cycle until 6 edges after release.
- Bounce: next_raw_n low 2 cycles, high 1, low 2, then high -> no next_pulse, next_held stays 0, FSM back in IDLE.
- Release bounce: after HELD, release for 2 cycles then re-press for 10 -> no second next_pulse; next_held stays 1.
- Switch update plus snapshot: din_raw 0->0xA, ms_raw 0->5 stable -> din_q = 0xA and ms_q = 5 six edges later with one sw_changed pulse; then a press -> din_snap = 0xA, ms_snap = 5.
- Coincident events: din_raw 0xA->0x3 timed so the update lands on the same edge as next_pulse -> din_snap = 0xA, din_q = 0x3.
- Reset mid-operation: clear low during PRESS_WAIT with the key held, then released while the key stays held -> outputs 0 asynchronously; next_pulse arrives 6 edges after clear deasserts (the 2 synchronizer edges count), not earlier.
